bcd_adjust: RTL and testbench
=============================

BCD_ADJUST -- requirements
Module: bcd_adjust

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: request to adjust; sampled only in IDLE.
REQ-004 SHALL have port D, input, 1 bit: decimal mode; 0 = binary pass-through.
REQ-005 SHALL have port sub, input, 1 bit: 0 = ADC correction, 1 = SBC correction.
REQ-006 SHALL have port R, input, 8 bits: binary ALU sum.
REQ-007 SHALL have port CI, input, 1 bit: binary carry out of bit 7 of the ALU sum.
REQ-008 SHALL have port HC, input, 1 bit: binary carry out of bit 3 of the ALU sum.
REQ-009 SHALL have port OUT, output, 8 bits, registered: adjusted result.
REQ-010 SHALL have port C, output, 1 bit, registered: decimal carry out.
REQ-011 SHALL have ports N and Z, outputs, 1 bit each, registered: N = OUT[7], Z = (OUT == 00).
REQ-012 SHALL have port busy, output, 1 bit: high in LO and HI states.
REQ-013 SHALL have port done, output, 1 bit: high for exactly one cycle in DONE.

Function
REQ-014 SHALL implement states IDLE, LO, HI, DONE.
REQ-015 On start=1 in IDLE, SHALL capture R, CI, HC, D and sub into internal registers (T, c, h, d, s).
- d=1: next state LO.
- d=0: next state DONE.
REQ-016 In LO, ADC case (s=0): if h=1 or T[3:0]>9, SHALL set T = T+06 (8-bit), and SHALL set c=1 on carry out of bit 7.
REQ-017 In LO, SBC case (s=1): if h=0, SHALL set T = T-06 (mod 256); c unchanged.
REQ-018 LO SHALL always be followed by HI.
REQ-019 In HI, ADC case: if c=1 or T[7:4]>9, SHALL set T = T+60 (mod 256) and c=1.
REQ-020 In HI, SBC case: if c=0, SHALL set T = T-60 (mod 256); c unchanged.
REQ-021 HI SHALL always be followed by DONE.
REQ-022 On entry to DONE, SHALL load OUT=T, C=c, N=T[7], Z=(T==00). done=1 for this one cycle; next state IDLE.
REQ-023 SHALL hold OUT, C, N and Z unchanged from DONE until the next DONE.
REQ-024 Latency, start cycle = 0: d=1 gives done at cycle 3; d=0 gives done at cycle 1, with OUT=R and C=CI.
REQ-025 SHALL ignore start in LO, HI and DONE; no queuing. A new start is accepted no earlier than the cycle after DONE.
REQ-026 HC for SBC SHALL mean "no borrow from the low nibble", and CI SHALL mean "no borrow" (6502 convention).
REQ-027 R, CI, HC, D and sub SHALL NOT affect state or outputs outside the start capture cycle.
REQ-028 Non-BCD operands SHALL follow REQ-016 to REQ-020 literally; no error flagging.

Reset
REQ-029 When RST=0 at a clock edge, the block SHALL enter IDLE with OUT=00, C=0, N=0, Z=1, busy=0, done=0, and internal registers cleared.
REQ-030 Reset during LO, HI or DONE SHALL abort the operation; no done pulse for it.
REQ-031 A start presented in the same cycle as RST=0 SHALL be ignored.

Verification
REQ-032 ADC, no fix-up: D=1, sub=0, R=3C, CI=0, HC=0 (15+27) -> done at cycle 3; OUT=42, C=0, N=0, Z=0.
REQ-033 ADC, both nibbles fixed: R=9E, CI=0, HC=0 (58+46) -> OUT=04, C=1. Also R=9A (99+01) -> OUT=00, C=1, Z=1.
REQ-034 SBC: sub=1, R=2D, CI=1, HC=0 (42-15) -> OUT=27, C=1. Also R=F0, CI=0, HC=1 (10-20) -> OUT=90, C=0, N=1.
REQ-035 Binary pass-through: D=0, R=FF, CI=1 -> done at cycle 1; OUT=FF, C=1, N=1, Z=0; busy never asserted.
REQ-036 Start while busy: a second start in LO and in HI -> ignored; exactly one done pulse; result from the first capture only.
REQ-037 Reset mid-operation: RST=0 in HI -> next cycle IDLE, OUT=00, Z=1, done stays 0. A subsequent start completes normally.

Source files
------------

// File: rtl/bcd_adjust.sv
// bcd_adjust -- multi-cycle decimal (BCD) correction of a binary ALU result.
//
// A start in IDLE captures the binary sum R with its carries CI/HC and the
// mode bits D/sub. In decimal mode the low nibble is corrected in LO, the
// high nibble in HI, and the result is published in DONE. In binary mode
// (D=0) the captured value is published directly, one cycle after start.
// SBC follows the 6502 convention: CI and HC mean "no borrow".
//
// Ports
//   clk            rising-edge clock
//   RST            synchronous active-low reset
//   start          request to adjust, sampled only in IDLE
//   D              decimal mode (0 = binary pass-through)
//   sub            0 = ADC correction, 1 = SBC correction
//   R[7:0]         binary ALU sum
//   CI             carry out of bit 7 of the sum
//   HC             carry out of bit 3 of the sum
//   OUT[7:0]       registered adjusted result
//   C              registered decimal carry
//   N, Z           registered sign (OUT[7]) and zero (OUT == 00) flags
//   busy           high while in LO or HI
//   done           one-cycle pulse in DONE
module bcd_adjust (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic       D,
  input  logic       sub,
  input  logic [7:0] R,
  input  logic       CI,
  input  logic       HC,
  output logic [7:0] OUT,
  output logic       C,
  output logic       N,
  output logic       Z,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] t_q, t_d;
  logic       c_q, c_d;
  logic       h_q, h_d;
  logic       d_q, d_d;
  logic       s_q, s_d;
  logic [7:0] out_q, out_d;
  logic       cout_q, cout_d;
  logic       n_q, n_d;
  logic       z_q, z_d;

  // 9-bit sum so the ADC low-nibble fix-up can see the carry out of bit 7.
  logic [8:0] lo_sum;
  logic [7:0] t_fix;
  logic       c_fix;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    c_d     = c_q;
    h_d     = h_q;
    d_d     = d_q;
    s_d     = s_q;
    out_d   = out_q;
    cout_d  = cout_q;
    n_d     = n_q;
    z_d     = z_q;
    lo_sum  = {1'b0, t_q} + 9'h006;
    t_fix   = t_q;
    c_fix   = c_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          t_d = R;
          c_d = CI;
          h_d = HC;
          d_d = D;
          s_d = sub;
          if (D) begin
            state_d = LO;
          end else begin
            // Pass-through publishes on the same edge that enters DONE.
            state_d = DONE;
            out_d   = R;
            cout_d  = CI;
            n_d     = R[7];
            z_d     = (R == 8'h00);
          end
        end
      end

      LO: begin
        state_d = HI;
        if (!s_q) begin
          if (h_q || (t_q[3:0] > 4'd9)) begin
            t_d = lo_sum[7:0];
            if (lo_sum[8]) c_d = 1'b1;
          end
        end else if (!h_q) begin
          t_d = t_q - 8'h06;
        end
      end

      HI: begin
        state_d = DONE;
        if (!s_q) begin
          if (c_q || (t_q[7:4] > 4'd9)) begin
            t_fix = t_q + 8'h60;
            c_fix = 1'b1;
          end
        end else if (!c_q) begin
          t_fix = t_q - 8'h60;
        end
        // The corrected value goes straight to the outputs so they are
        // already valid in the DONE cycle.
        t_d    = t_fix;
        c_d    = c_fix;
        out_d  = t_fix;
        cout_d = c_fix;
        n_d    = t_fix[7];
        z_d    = (t_fix == 8'h00);
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q <= IDLE;
      t_q     <= '0;
      c_q     <= 1'b0;
      h_q     <= 1'b0;
      d_q     <= 1'b0;
      s_q     <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      c_q     <= c_d;
      h_q     <= h_d;
      d_q     <= d_d;
      s_q     <= s_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  assign OUT  = out_q;
  assign C    = cout_q;
  assign N    = n_q;
  assign Z    = z_q;
  // LO/HI are only reachable with d captured as 1, so qualifying busy with
  // it changes nothing functionally.
  assign busy = d_q && ((state_q == LO) || (state_q == HI));
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_bcd_adjust.sv
module tb_bcd_adjust;

  logic       clk = 1'b0;
  logic       RST;
  logic       start;
  logic       D;
  logic       sub;
  logic [7:0] R;
  logic       CI;
  logic       HC;
  logic [7:0] OUT;
  logic       C;
  logic       N;
  logic       Z;
  logic       busy;
  logic       done;

  bcd_adjust dut (
    .clk  (clk),
    .RST  (RST),
    .start(start),
    .D    (D),
    .sub  (sub),
    .R    (R),
    .CI   (CI),
    .HC   (HC),
    .OUT  (OUT),
    .C    (C),
    .N    (N),
    .Z    (Z),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] out;
    logic       c;
    int         at;
    string      tag;
  } exp_t;

  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] last_out;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending result", cyc);
      end else begin
        chk({sb[0].tag, "_cycle"}, cyc, sb[0].at);
        chk({sb[0].tag, "_OUT"}, int'(OUT), int'(sb[0].out));
        chk({sb[0].tag, "_C"}, int'(C), int'(sb[0].c));
        chk({sb[0].tag, "_N"}, int'(N), int'(sb[0].out[7]));
        chk({sb[0].tag, "_Z"}, int'(Z), int'(sb[0].out == 8'h00));
        chk({sb[0].tag, "_busy"}, int'(busy), 0);
        void'(sb.pop_front());
      end
    end else if (sb.size() != 0 && cyc > sb[0].at) begin
      n_total++;
      $display("FAIL %s_timeout: got no done by cycle %0d expected done at %0d",
               sb[0].tag, cyc, sb[0].at);
      void'(sb.pop_front());
    end
  end

  task automatic scramble();
    D   = 1'($urandom);
    sub = 1'($urandom);
    R   = 8'($urandom);
    CI  = 1'($urandom);
    HC  = 1'($urandom);
  endtask

  // One transaction; returns once the DUT is in DONE, so the next issue
  // lands on the first cycle a start can be accepted again.
  task automatic issue(input bit d, input bit s, input logic [7:0] r, input bit ci,
                       input bit hc, input logic [7:0] eo, input bit ec, input string tag);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; D = d; sub = s; R = r; CI = ci; HC = hc;
    e.out = eo; e.c = ec; e.at = cyc + (d ? 3 : 1); e.tag = tag;
    sb.push_back(e);
    last_out = eo;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    repeat (d ? 2 : 0) @(posedge clk);
  endtask

  // Literal correction rules in plain integer arithmetic; returns {C, OUT}.
  function automatic logic [8:0] ref_literal(input bit d, input bit s, input int r,
                                             input bit ci, input bit hc);
    int t;
    bit c;
    t = r;
    c = ci;
    if (d) begin
      if (!s) begin
        if (hc || (t % 16) > 9) begin
          t = t + 6;
          if (t > 255) c = 1'b1;
          t = t % 256;
        end
        if (c || (t / 16) > 9) begin
          t = (t + 96) % 256;
          c = 1'b1;
        end
      end else begin
        if (!hc) t = (t + 256 - 6) % 256;
        if (!ci) t = (t + 256 - 96) % 256;
      end
    end
    return {c, 8'(t)};
  endfunction

  // Decimal arithmetic on random BCD operands; the ALU inputs are derived
  // the way a 6502 binary adder would produce them.
  task automatic rand_bcd(input bit s);
    int a_hi, a_lo, b_hi, b_lo, cin, ab, bb, bin, r, v;
    bit ci, hc, ec;
    a_hi = int'($urandom_range(9, 0)); a_lo = int'($urandom_range(9, 0));
    b_hi = int'($urandom_range(9, 0)); b_lo = int'($urandom_range(9, 0));
    cin  = int'($urandom_range(1, 0));
    ab = a_hi * 16 + a_lo;
    bb = b_hi * 16 + b_lo;
    if (!s) begin
      bin = ab + bb + cin;
      r   = bin % 256;
      ci  = (bin > 255);
      hc  = (a_lo + b_lo + cin) > 15;
      v   = (a_hi * 10 + a_lo) + (b_hi * 10 + b_lo) + cin;
      ec  = (v >= 100);
      v   = v % 100;
    end else begin
      bin = ab - bb - (1 - cin);
      r   = (bin + 256) % 256;
      ci  = (bin >= 0);
      hc  = (a_lo - b_lo - (1 - cin)) >= 0;
      v   = (a_hi * 10 + a_lo) - (b_hi * 10 + b_lo) - (1 - cin);
      ec  = (v >= 0);
      if (v < 0) v = v + 100;
    end
    issue(1'b1, s, 8'(r), ci, hc, 8'((v / 10) * 16 + (v % 10)), ec, s ? "bcd_sbc" : "bcd_adc");
  endtask

  task automatic rand_literal();
    bit d, s, ci, hc;
    logic [7:0] r;
    logic [8:0] e;
    d = 1'($urandom); s = 1'($urandom); ci = 1'($urandom); hc = 1'($urandom);
    r = 8'($urandom);
    e = ref_literal(d, s, int'(r), ci, hc);
    issue(d, s, r, ci, hc, e[7:0], e[8], d ? "lit_dec" : "lit_bin");
  endtask

  initial begin
    RST = 1'b0; start = 1'b0;
    scramble();
    last_out = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_OUT", int'(OUT), 0);
    chk("rst_C", int'(C), 0);
    chk("rst_N", int'(N), 0);
    chk("rst_Z", int'(Z), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk); #1;
    RST = 1'b1;

    // Directed ADC with busy profile LO/HI/DONE
    fork
      issue(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h42, 1'b0, "adc_15_27");
      begin
        @(posedge clk); @(posedge clk);
        @(negedge clk); chk("busy_lo", int'(busy), 1);
        @(negedge clk); chk("busy_hi", int'(busy), 1);
        @(negedge clk); chk("busy_done", int'(busy), 0);
      end
    join
    issue(1'b1, 1'b0, 8'h9E, 1'b0, 1'b0, 8'h04, 1'b1, "adc_58_46");
    issue(1'b1, 1'b0, 8'h9A, 1'b0, 1'b0, 8'h00, 1'b1, "adc_99_01");
    issue(1'b1, 1'b1, 8'h2D, 1'b1, 1'b0, 8'h27, 1'b1, "sbc_42_15");
    issue(1'b1, 1'b1, 8'hF0, 1'b0, 1'b1, 8'h90, 1'b0, "sbc_10_20");
    fork
      issue(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "pass_FF");
      begin
        repeat (4) begin
          @(negedge clk); chk("busy_passthru", int'(busy), 0);
        end
      end
    join

    // Start while busy: further starts in LO, HI and DONE must be ignored
    begin
      exp_t e;
      @(posedge clk); #1;
      start = 1'b1; D = 1'b1; sub = 1'b0; R = 8'h9E; CI = 1'b0; HC = 1'b0;
      e.out = 8'h04; e.c = 1'b1; e.at = cyc + 3; e.tag = "busy_first";
      sb.push_back(e);
      @(posedge clk); #1; R = 8'h3C; D = 1'b1; HC = 1'b1;
      @(posedge clk); #1; R = 8'h11; D = 1'b0; CI = 1'b1;
      @(posedge clk); #1; R = 8'h55; D = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(posedge clk);
    end

    // Reset in HI aborts without a done pulse
    @(posedge clk); #1;
    start = 1'b1; D = 1'b1; sub = 1'b0; R = 8'h77; CI = 1'b0; HC = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; RST = 1'b0;
    @(posedge clk); #1; RST = 1'b1;
    chk("abort_OUT", int'(OUT), 0);
    chk("abort_Z", int'(Z), 1);
    chk("abort_C", int'(C), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    issue(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h42, 1'b0, "after_abort");
    repeat (2) @(posedge clk);

    // Start coincident with reset is ignored
    @(posedge clk); #1;
    RST = 1'b0; start = 1'b1; D = 1'b0; R = 8'h77; CI = 1'b1;
    @(posedge clk); #1;
    RST = 1'b1; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rststart_busy", int'(busy), 0);
      chk("rststart_OUT", int'(OUT), 0);
    end

    // Randomized traffic
    for (int i = 0; i < 30; i++) rand_bcd(1'($urandom));
    for (int i = 0; i < 30; i++) rand_literal();

    // Outputs hold while idle with inputs toggling
    @(posedge clk);
    repeat (6) begin
      @(posedge clk); #1; scramble();
      @(negedge clk); chk("hold_OUT", int'(OUT), int'(last_out));
    end

    // Drain with a bounded wait
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
